// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage between the instruction ROM and decode.
// Owns the PC, issues one ROM word read per cycle, and buffers the ROM's
// one-cycle-late responses in a 2-entry FIFO so decode stalls never drop or
// duplicate a word. A one-cycle REDIRECT flushes everything in flight and
// issues the target in the same cycle.
//
// Ports:
//   CLK, RST_N        clock, asynchronous active-low reset
//   REDIRECT          one-cycle restart request
//   REDIRECT_PC       byte target of the restart (bits [1:0] forced to 0)
//   IMEM_RDEN         ROM read enable (combinational)
//   IMEM_ADDR         ROM word address (combinational)
//   IMEM_DATA         ROM read data, valid the cycle after IMEM_RDEN
//   INSTR_VALID       buffer head holds an instruction
//   INSTR_READY       decode accepts the head this cycle
//   INSTR, INSTR_PC   head instruction word and its byte address
module fetch_unit #(
  parameter int unsigned ADDR_DEPTH = 14,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  output logic                  IMEM_RDEN,
  output logic [ADDR_DEPTH-1:0] IMEM_ADDR,
  input  logic [31:0]           IMEM_DATA,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [31:0]           INSTR,
  output logic [31:0]           INSTR_PC
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [XLEN-1:0]  fifo_instr_q [DEPTH];
  logic [XLEN-1:0]  fifo_instr_d [DEPTH];
  logic [XLEN-1:0]  fifo_pc_q [DEPTH];
  logic [XLEN-1:0]  fifo_pc_d [DEPTH];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       occ;
  logic [XLEN-1:0]  target;
  logic [XLEN-1:0]  issue_pc;

  assign INSTR_VALID = (count_q != '0);
  assign INSTR       = fifo_instr_q[rd_ptr_q];
  assign INSTR_PC    = fifo_pc_q[rd_ptr_q];

  // Issue decision, ROM request and next-state for PC, in-flight tag and FIFO.
  always_comb begin
    pop        = INSTR_VALID & INSTR_READY;
    push       = pend_q & ~REDIRECT;
    target     = REDIRECT_PC & ~32'h3;
    occ        = 3'(count_q) + 3'(pend_q);
    // Buffered plus in-flight words after this cycle's pop must leave a slot
    // for the word requested now; a pop in the same cycle frees one.
    issue      = REDIRECT | (occ <= (3'd1 + 3'(pop)));
    issue_pc   = REDIRECT ? target : pc_q;
    IMEM_RDEN  = RST_N & issue;
    IMEM_ADDR  = issue_pc[ADDR_DEPTH+1:2];

    pc_d         = pc_q;
    pend_d       = issue;
    pend_pc_d    = pend_pc_q;
    fifo_instr_d = fifo_instr_q;
    fifo_pc_d    = fifo_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;

    if (issue) begin
      pc_d      = issue_pc + 32'd4;
      pend_pc_d = issue_pc;
    end

    if (push) begin
      fifo_instr_d[wr_ptr_q] = IMEM_DATA;
      fifo_pc_d[wr_ptr_q]    = pend_pc_q;
    end

    // Redirect drops buffered words and the response still in flight.
    if (REDIRECT) begin
      count_d  = '0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
    end
  end

  // State registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_pc_q    <= '0;
      fifo_instr_q <= '{default: '0};
      fifo_pc_q    <= '{default: '0};
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_pc_q    <= pend_pc_d;
      fifo_instr_q <= fifo_instr_d;
      fifo_pc_q    <= fifo_pc_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

endmodule
